// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the sequential ALU.
// Helper is_iter_op flags the multi-cycle multiply/divide opcodes (12-15).
package alu_pkg;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_COPYA = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_MULHU = 4'd13;
    localparam logic [3:0] OP_DIVU  = 4'd14;
    localparam logic [3:0] OP_REMU  = 4'd15;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per cycle.
// Takes exactly XLEN steps after start; done flags the cycle of the final step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic              busy;
    logic [CW-1:0]     count;
    logic [3:0]        op_q;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_next;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    // A zero divisor never borrows, so the quotient fills with ones and the
    // remainder shifts in the dividend unchanged: no special case is needed.
    always_comb begin
        mul_addend = prod[0] ? mcand : {XLEN{1'b0}};
        mul_sum    = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        prod_next  = {mul_sum, prod[XLEN-1:1]};
        div_shift  = {rem, quo[XLEN-1]};
        div_diff   = div_shift - {1'b0, divisor};
        if (!div_diff[XLEN]) begin
            rem_next = div_diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = div_shift[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

    assign done = busy && (count == CW'(XLEN - 1));

    always_comb begin
        case (op_q)
            OP_MUL:   result = prod_next[XLEN-1:0];
            OP_MULHU: result = prod_next[2*XLEN-1:XLEN];
            OP_DIVU:  result = quo_next;
            default:  result = rem_next;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            count   <= '0;
            op_q    <= '0;
            prod    <= '0;
            mcand   <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            count   <= '0;
            op_q    <= op;
            prod    <= {{XLEN{1'b0}}, b};
            mcand   <= a;
            quo     <= a;
            rem     <= '0;
            divisor <= b;
        end else if (busy) begin
            prod  <= prod_next;
            quo   <= quo_next;
            rem   <= rem_next;
            count <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and an IDLE/BUSY/DONE FSM.
// Define ALU_SEQ_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU unit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            io_req_valid,
    output logic            io_req_ready,
    input  logic [XLEN-1:0] io_a,
    input  logic [XLEN-1:0] io_b,
    input  logic [3:0]      io_op,
    output logic            io_resp_valid,
    input  logic            io_resp_ready,
    output logic [XLEN-1:0] io_out,
    output logic            io_zero
);

    state_t          state;
    logic            handshake;
    logic            iter_op;
    logic            iter_done;
    logic [XLEN-1:0] iter_result;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;

    assign io_req_ready  = (state == IDLE);
    assign io_resp_valid = (state == DONE);
    assign handshake     = io_req_valid && io_req_ready;
    assign shamt         = io_b[SHW-1:0];

`ifdef ALU_SEQ_MULDIV_EN
    assign iter_op = is_iter_op(io_op);

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (handshake && iter_op),
        .op      (io_op),
        .a       (io_a),
        .b       (io_b),
        .done    (iter_done),
        .result  (iter_result)
    );
`else
    assign iter_op     = 1'b0;
    assign iter_done   = 1'b0;
    assign iter_result = '0;
`endif

    // Opcodes 12-15 fall into the default and yield zero when the iterative unit is absent.
    always_comb begin
        case (io_op)
            OP_ADD:   alu_res = io_a + io_b;
            OP_SUB:   alu_res = io_a - io_b;
            OP_AND:   alu_res = io_a & io_b;
            OP_OR:    alu_res = io_a | io_b;
            OP_XOR:   alu_res = io_a ^ io_b;
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(io_a) < $signed(io_b))};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (io_a < io_b)};
            OP_SLL:   alu_res = io_a << shamt;
            OP_SRL:   alu_res = io_a >> shamt;
            OP_SRA:   alu_res = XLEN'($signed(io_a) >>> shamt);
            OP_COPYA: alu_res = io_a;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            io_out  <= '0;
            io_zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (iter_op) begin
                            state <= BUSY;
                        end else begin
                            io_out  <= alu_res;
                            io_zero <= (alu_res == '0);
                            state   <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (iter_done) begin
                        io_out  <= iter_result;
                        io_zero <= (iter_result == '0);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (io_resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (XLEN=32); expectations follow ALU_SEQ_MULDIV_EN.
// Results are queued at handshake and popped when io_resp_valid rises.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] result;
        int          latency;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [31:0] io_a;
    logic [31:0] io_b;
    logic [3:0]  io_op;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [31:0] io_out;
    logic        io_zero;

    exp_t sb[$];
    int   num_checks = 0;
    int   num_errors = 0;

    alu_seq dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_a          (io_a),
        .io_b          (io_b),
        .io_op         (io_op),
        .io_resp_valid (io_resp_valid),
        .io_resp_ready (io_resp_ready),
        .io_out        (io_out),
        .io_zero       (io_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        logic [4:0]  sh;
        sh = b[4:0];
        wide = 64'd0;
        case (op)
            OP_ADD:   model = a + b;
            OP_SUB:   model = a - b;
            OP_AND:   model = a & b;
            OP_OR:    model = a | b;
            OP_XOR:   model = a ^ b;
            OP_SLT:   model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  model = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:   model = a << sh;
            OP_SRL:   model = a >> sh;
            OP_SRA: begin
                wide  = {{32{a[31]}}, a} >> sh;
                model = wide[31:0];
            end
            OP_COPYA: model = a;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL: begin
                wide  = {32'd0, a} * {32'd0, b};
                model = wide[31:0];
            end
            OP_MULHU: begin
                wide  = {32'd0, a} * {32'd0, b};
                model = wide[63:32];
            end
            OP_DIVU:  model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:  model = (b == 32'd0) ? a : a % b;
`endif
            default:  model = 32'd0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op);
`ifdef ALU_SEQ_MULDIV_EN
        if (op >= OP_MUL) return 33;
`endif
        return (op == 4'd0) ? 1 : 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic issueRequest(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        int   w;
        @(negedge clk);
        io_req_valid = 1'b1;
        io_op = op;
        io_a  = a;
        io_b  = b;
        w = 0;
        while (!io_req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!io_req_ready) begin
            checkOutput({tag, "_req_timeout"}, 64'd0, 64'd1);
            io_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.result  = model(op, a, b);
        e.latency = model_latency(op);
        e.tag     = tag;
        sb.push_back(e);
        #1;
        io_req_valid = 1'b0;
        io_a  = $urandom;
        io_b  = $urandom;
        io_op = 4'($urandom);
    endtask

    task automatic awaitResponse(input int hold);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io_resp_valid && n < 200);
        if (!io_resp_valid) begin
            checkOutput("resp_timeout", 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput({e.tag, "_out"}, 64'(io_out), 64'(e.result));
        checkOutput({e.tag, "_zero"}, 64'(io_zero), 64'(e.result == 32'd0));
        checkOutput({e.tag, "_latency"}, 64'(n), 64'(e.latency));
        for (int i = 0; i < hold; i++) begin
            io_req_valid = 1'b1;
            io_op = OP_ADD;
            io_a  = $urandom;
            io_b  = $urandom;
            @(negedge clk);
            checkOutput("hold_out", 64'(io_out), 64'(e.result));
            checkOutput("hold_req_ready", 64'(io_req_ready), 64'd0);
            checkOutput("hold_resp_valid", 64'(io_resp_valid), 64'd1);
        end
        io_req_valid  = 1'b0;
        io_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        io_resp_ready = 1'b0;
        if (hold > 0) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checkOutput("no_extra_resp", 64'(io_resp_valid), 64'd0);
                checkOutput("idle_req_ready", 64'(io_req_ready), 64'd1);
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        issueRequest(op, a, b, tag);
        awaitResponse(0);
    endtask

    initial begin
        reset_n       = 1'b0;
        io_req_valid  = 1'b0;
        io_resp_ready = 1'b0;
        io_a          = 32'd0;
        io_b          = 32'd0;
        io_op         = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp_valid", 64'(io_resp_valid), 64'd0);
        checkOutput("rst_out", 64'(io_out), 64'd0);
        checkOutput("rst_zero", 64'(io_zero), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(io_req_ready), 64'd1);

        applyStimulus(OP_ADD,   32'd7,          32'd5,          "add_7_5");
        applyStimulus(OP_SUB,   32'd5,          32'd5,          "sub_5_5");
        applyStimulus(OP_SRA,   32'h8000_0000,  32'h24,         "sra");
        applyStimulus(OP_SLT,   32'hFFFF_FFFF,  32'd1,          "slt");
        applyStimulus(OP_SLTU,  32'hFFFF_FFFF,  32'd1,          "sltu");
        applyStimulus(OP_AND,   32'hF0F0_1234,  32'h0FF0_FF00,  "and");
        applyStimulus(OP_OR,    32'hF000_0001,  32'h0000_0F10,  "or");
        applyStimulus(OP_XOR,   32'hA5A5_A5A5,  32'hA5A5_A5A5,  "xor_self");
        applyStimulus(OP_SLL,   32'h0000_0003,  32'h0000_003F,  "sll_31");
        applyStimulus(OP_SRL,   32'h8000_0000,  32'h0000_0021,  "srl_1");
        applyStimulus(OP_COPYA, 32'hDEAD_BEEF,  32'h1234_5678,  "copy_a");
        applyStimulus(OP_ZERO,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  "op_zero");
        applyStimulus(OP_MUL,   32'h0000_FFFF,  32'h0001_0001,  "mul");
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mulhu");
        applyStimulus(OP_DIVU,  32'd100,        32'd7,          "divu");
        applyStimulus(OP_REMU,  32'd100,        32'd7,          "remu");
        applyStimulus(OP_DIVU,  32'h1234_5678,  32'd0,          "divu_by0");
        applyStimulus(OP_REMU,  32'd9,          32'd0,          "remu_by0");

        issueRequest(OP_XOR, 32'h0F0F_0F0F, 32'h00FF_00FF, "hold_xor");
        awaitResponse(5);

        issueRequest(OP_DIVU, 32'd1000, 32'd3, "rst_divu");
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_resp_valid", 64'(io_resp_valid), 64'd0);
        checkOutput("midrst_req_ready", 64'(io_req_ready), 64'd1);
        checkOutput("midrst_out", 64'(io_out), 64'd0);
        checkOutput("midrst_zero", 64'(io_zero), 64'd1);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("postrst_no_resp", 64'(io_resp_valid), 64'd0);
        end
        applyStimulus(OP_ADD, 32'd1, 32'd1, "add_after_rst");

        for (int i = 0; i < 24; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; SHALL be at least 8 and a power of two.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width taken from io_b[SHW-1:0].
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 io_req_valid  input  1  request present.
REQ-006 io_req_ready  output  1  block can accept a request.
REQ-007 io_a, io_b  input  XLEN  operands, sampled at request handshake.
REQ-008 io_op  input  4  operation code, sampled at request handshake.
REQ-009 io_resp_valid  output  1  result present.
REQ-010 io_resp_ready  input  1  consumer accepts the result.
REQ-011 io_out  output  XLEN  result.
REQ-012 io_zero  output  1  high when io_out == 0, valid with io_resp_valid.

Function
REQ-013 Opcodes SHALL be: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 COPY_A, 0 = result 0, 12 MUL (low XLEN), 13 MULHU (high XLEN, unsigned), 14 DIVU, 15 REMU.
REQ-014 Arithmetic SHALL wrap modulo 2^XLEN; SLT and SLTU SHALL return zero-extended 1 or 0; shifts SHALL use io_b[SHW-1:0] only.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; io_req_ready = (state == IDLE).
REQ-016 IDLE, handshake, opcode 0-11: result registered; state goes to DONE; io_resp_valid is high on the next cycle (latency 1).
REQ-017 IDLE, handshake, opcode 12-15: state goes to BUSY for exactly XLEN cycles (one iteration per cycle), then to DONE; io_resp_valid is first high XLEN+1 cycles after the handshake.
REQ-018 MUL and MULHU SHALL use unsigned shift-add over a 2*XLEN product register.
REQ-019 DIVU and REMU SHALL use restoring division.
REQ-020 Division by zero: DIVU SHALL return all ones; REMU SHALL return io_a; latency SHALL be unchanged.
REQ-021 DONE: io_out and io_zero SHALL stay stable until io_resp_ready is high; in that cycle the state returns to IDLE.
REQ-022 No new request is accepted in the DONE cycle; maximum throughput for single-cycle ops is one result per 2 cycles.
REQ-023 io_req_valid during BUSY or DONE SHALL be ignored; operand changes after the handshake SHALL NOT affect the result.

Reset
REQ-024 Assertion of reset_n low SHALL force IDLE immediately, asynchronously.
REQ-025 Reset values: io_req_ready=1 once reset is released, io_resp_valid=0, io_out=0, io_zero=1; iteration counter and partial registers are cleared.
REQ-026 Reset during BUSY or DONE SHALL discard the operation with no response.

Configuration
REQ-027 Macro ALU_SEQ_MULDIV_EN defined: opcodes 12-15 follow REQ-017 to REQ-020.
REQ-028 Macro ALU_SEQ_MULDIV_EN undefined: the iterative hardware is absent; opcodes 12-15 behave as opcode 0 (result 0, latency 1, io_zero=1), and BUSY is never entered.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants and the state enumeration typedef (IDLE/BUSY/DONE).
REQ-030 Sub-module alu_muldiv_iter (start, op, a, b -> done, result, parameter XLEN) SHALL hold the iterative multiply/divide; it is instantiated only under ALU_SEQ_MULDIV_EN.

Verification
REQ-031 ADD a=7, b=5 -> io_out=12, io_zero=0, io_resp_valid high 1 cycle after the handshake; SUB 5-5 -> 0, io_zero=1.
REQ-032 SRA a=0x80000000, b=0x24 -> 0xF8000000 (shift 4); SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-033 MUL a=0xFFFF, b=0x10001 -> 0xFFFFFFFF; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; each with io_resp_valid high 33 cycles after the handshake.
REQ-034 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-035 Hold io_resp_ready=0 for 5 cycles in DONE -> io_out stable and io_req_ready=0 throughout; a request offered during this time is not accepted.
REQ-036 Pulse reset_n low mid-BUSY on a DIVU -> io_resp_valid=0 immediately; after release, ADD 1+1 -> 2 with normal latency.
